bnn_mlp_sequencer: RTL and testbench

//  Sequences one shared 4-neuron BNN_MLP layer datapath through up to NUM_LAYERS layers.

---
 rtl/bnn_mlp_sequencer_pkg.sv | 8 +
 rtl/bnn_layer_regfile.sv | 20 ++
 rtl/bnn_mlp_sequencer.sv | 98 +++++++++
 tb/tb_bnn_mlp_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bnn_mlp_sequencer_pkg.sv
// bnn_mlp_sequencer_pkg: shared FSM encoding and config word field positions.
package bnn_mlp_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, CAPTURE, DONE} state_e;
   localparam int CFG_W_MSB = 31;
   localparam int CFG_W_LSB = 16;
   localparam int CFG_B_MSB = 15;
   localparam int CFG_B_LSB = 0;
endpackage

// File: rtl/bnn_layer_regfile.sv
// bnn_layer_regfile: per-layer weight/bias words, one write port, one combinational read port, sync clear.
module bnn_layer_regfile #(
   parameter int NUM_LAYERS = 4,
   parameter int LAYER_AW   = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we_i,
   input  logic [LAYER_AW-1:0] waddr_i,
   input  logic [31:0]         wdata_i,
   input  logic [LAYER_AW-1:0] raddr_i,
   output logic [31:0]         rdata_o
);
   logic [31:0] mem_q [NUM_LAYERS];
   always_ff @(posedge clk) begin
      if (reset) mem_q <= '{default: '0};
      else if (we_i && 32'(waddr_i) < 32'(NUM_LAYERS)) mem_q[waddr_i] <= wdata_i;
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/bnn_mlp_sequencer.sv
// bnn_mlp_sequencer: runs one shared 4-neuron BNN layer datapath through up to NUM_LAYERS layers.
module bnn_mlp_sequencer
   import bnn_mlp_sequencer_pkg::*;
#(
   parameter int NUM_LAYERS = 4,
   parameter int LAYER_AW   = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [LAYER_AW-1:0] cfg_addr,
   input  logic [31:0]         cfg_wdata,
   input  logic                start,
   input  logic [LAYER_AW:0]   n_layers,
   input  logic [3:0]          data_in,
   output logic                busy,
   output logic                done,
   output logic [3:0]          result,
   output logic                trig,
   output logic [3:0]          mlp_input,
   output logic [15:0]         mlp_weights,
   output logic [15:0]         mlp_bias,
   input  logic [3:0]          mlp_result
);
   state_e              state_q, state_d;
   logic [3:0]          act_q, act_d, result_q, result_d, mlp_input_q, mlp_input_d;
   logic [LAYER_AW:0]   cnt_max_q, cnt_max_d, n_clamped;
   logic [LAYER_AW-1:0] k_q, k_d;
   logic [15:0]         mlp_weights_q, mlp_weights_d, mlp_bias_q, mlp_bias_d;
   logic                done_q, done_d, accept, last;
   logic [31:0]         rf_rdata;

   bnn_layer_regfile #(.NUM_LAYERS(NUM_LAYERS), .LAYER_AW(LAYER_AW)) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .we_i    (cfg_we && state_q == IDLE),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_wdata),
      .raddr_i (k_q),
      .rdata_o (rf_rdata)
   );

   assign accept    = state_q == IDLE && start;
   assign last      = (LAYER_AW+1)'(k_q) == cnt_max_q - 1'b1;
   assign n_clamped = n_layers == '0 ? (LAYER_AW+1)'(1)
                    : n_layers > (LAYER_AW+1)'(NUM_LAYERS) ? (LAYER_AW+1)'(NUM_LAYERS) : n_layers;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         act_q         <= '0;
         cnt_max_q     <= '0;
         k_q           <= '0;
         result_q      <= '0;
         done_q        <= 1'b0;
         mlp_input_q   <= '0;
         mlp_weights_q <= '0;
         mlp_bias_q    <= '0;
      end else begin
         state_q       <= state_d;
         act_q         <= act_d;
         cnt_max_q     <= cnt_max_d;
         k_q           <= k_d;
         result_q      <= result_d;
         done_q        <= done_d;
         mlp_input_q   <= mlp_input_d;
         mlp_weights_q <= mlp_weights_d;
         mlp_bias_q    <= mlp_bias_d;
      end
   end

   always_comb begin
      state_d = state_q == IDLE    ? (start ? SETUP : IDLE)
              : state_q == SETUP   ? CAPTURE
              : state_q == CAPTURE ? (last ? DONE : SETUP)
              : IDLE;
   end

   // done and result are registered on the DONE edge so they appear together
   always_comb begin
      act_d         = accept ? data_in : state_q == CAPTURE ? mlp_result : act_q;
      cnt_max_d     = accept ? n_clamped : cnt_max_q;
      k_d           = accept ? '0 : (state_q == CAPTURE && !last) ? k_q + 1'b1 : k_q;
      mlp_input_d   = state_q == SETUP ? act_q : mlp_input_q;
      mlp_weights_d = state_q == SETUP ? rf_rdata[CFG_W_MSB:CFG_W_LSB] : mlp_weights_q;
      mlp_bias_d    = state_q == SETUP ? rf_rdata[CFG_B_MSB:CFG_B_LSB] : mlp_bias_q;
      result_d      = state_q == DONE ? act_q : result_q;
      done_d        = state_q == DONE;
      busy          = state_q != IDLE;
      trig          = state_q == SETUP || state_q == CAPTURE;
   end

   assign done        = done_q;
   assign result      = result_q;
   assign mlp_input   = mlp_input_q;
   assign mlp_weights = mlp_weights_q;
   assign mlp_bias    = mlp_bias_q;
endmodule

// File: tb/tb_bnn_mlp_sequencer.sv
// tb_bnn_mlp_sequencer: directed runs against a timeline model of the sequencer with an increment datapath stub.
module tb_bnn_mlp_sequencer;
   logic        clk = 1'b0, reset = 1'b1, cfg_we = 1'b0, start = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic [2:0]  n_layers = '0;
   logic [3:0]  data_in = '0;
   logic        busy, done, trig;
   logic [3:0]  result, mlp_input, mlp_result;
   logic [15:0] mlp_weights, mlp_bias;
   int          checks = 0, errors = 0;
   bit          chk_en = 1'b0;

   always #5 clk = ~clk;
   assign mlp_result = mlp_input + 4'd1;

   bnn_mlp_sequencer #(.NUM_LAYERS(4), .LAYER_AW(2)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start(start), .n_layers(n_layers), .data_in(data_in), .busy(busy), .done(done),
      .result(result), .trig(trig), .mlp_input(mlp_input), .mlp_weights(mlp_weights),
      .mlp_bias(mlp_bias), .mlp_result(mlp_result)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: edges since the accepted start; busy for 2n+1 cycles, layer k set up on edge 2k+1
   logic [31:0] m_rf [4];
   int          m_t = -1, m_n = 1, k;
   logic [3:0]  m_d, m_res, m_mi;
   logic [15:0] m_mw, m_mb;
   bit          m_done;

   always @(posedge clk) begin
      if (reset) begin
         foreach (m_rf[i]) m_rf[i] = '0;
         m_t = -1; m_res = '0; m_done = 1'b0; m_mi = '0; m_mw = '0; m_mb = '0;
      end else begin
         m_done = 1'b0;
         if (m_t < 0) begin
            if (cfg_we) m_rf[cfg_addr] = cfg_wdata;
            if (start) begin
               m_n = n_layers == 0 ? 1 : n_layers > 4 ? 4 : int'(n_layers);
               m_d = data_in;
               m_t = 0;
            end
         end else begin
            m_t++;
            if (m_t % 2 == 1 && m_t < 2 * m_n) begin
               k = m_t / 2;
               m_mi = 4'(int'(m_d) + k);
               m_mw = m_rf[k][31:16];
               m_mb = m_rf[k][15:0];
            end
            if (m_t == 2 * m_n + 1) begin
               m_t = -1;
               m_done = 1'b1;
               m_res = 4'(int'(m_d) + m_n);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_t >= 0);
         chk("trig", trig, m_t >= 0 && m_t < 2 * m_n);
         chk("done", done, m_done);
         chk("result", result, m_res);
         chk("mlp_input", mlp_input, m_mi);
         chk("mlp_weights", mlp_weights, m_mw);
         chk("mlp_bias", mlp_bias, m_mb);
      end
   end

   task automatic cfg(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1 cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(posedge clk); #1 cfg_we = 1'b0;
   endtask

   task automatic start_run(input logic [2:0] n, input logic [3:0] d);
      @(posedge clk); #1 start = 1'b1; n_layers = n; data_in = d;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // called just after the start edge; lat = edges from start edge to the done cycle
   task automatic measure(input bit inj, output int lat, output int bc, output int tc,
                          output logic [3:0] res, output logic [3:0][15:0] w, output logic [3:0][15:0] b);
      lat = 0; bc = 0; tc = 0; w = '0; b = '0; res = '0;
      forever begin
         @(negedge clk);
         if (busy) bc++;
         if (trig) tc++;
         if (lat % 2 == 1 && lat < 8) begin w[lat/2] = mlp_weights; b[lat/2] = mlp_bias; end
         if (inj && lat == 3) begin
            cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'hDEAD_BEEF;
            start = 1'b1; n_layers = 3'd1; data_in = 4'h9;
         end else if (inj && lat == 4) begin
            cfg_we = 1'b0; start = 1'b0;
         end
         if (done) begin res = result; break; end
         if (lat >= 40) begin chk("done_timeout", 0, 1); break; end
         @(posedge clk); lat++;
      end
   endtask

   int               lat, bc, tc, dcnt;
   logic [3:0]       res;
   logic [3:0][15:0] w, b;

   initial begin
      @(posedge clk); chk_en = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_result", result, 0);
      chk("rst_weights", mlp_weights, 0);
      start_run(3'd4, 4'h3); measure(0, lat, bc, tc, res, w, b);
      chk("t1_latency", lat, 9); chk("t1_result", res, 4'h7);
      chk("t1_busy_cycles", bc, 9); chk("t1_trig_cycles", tc, 8);
      cfg(2'd2, 32'hA5A5_0F0F);
      start_run(3'd4, 4'h3); measure(0, lat, bc, tc, res, w, b);
      chk("t2_l2_weights", w[2], 16'hA5A5); chk("t2_l2_bias", b[2], 16'h0F0F);
      start_run(3'd0, 4'hF); measure(0, lat, bc, tc, res, w, b);
      chk("t3_n0_latency", lat, 3); chk("t3_n0_result", res, 4'h0);
      start_run(3'd7, 4'h0); measure(0, lat, bc, tc, res, w, b);
      chk("t3_n7_latency", lat, 9); chk("t3_n7_result", res, 4'h4);
      @(posedge clk); #1 start = 1'b1; n_layers = 3'd4; data_in = 4'h1;
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h1234_5678;
      @(posedge clk); #1 start = 1'b0; cfg_we = 1'b0;
      measure(1, lat, bc, tc, res, w, b);
      chk("t4_l0_weights", w[0], 16'h1234); chk("t4_l0_bias", b[0], 16'h5678);
      chk("t5_result", res, 4'h5);
      dcnt = 0;
      repeat (10) begin @(negedge clk); if (done || busy) dcnt++; end
      chk("t5_no_queued_run", dcnt, 0);
      start_run(3'd4, 4'h0); measure(0, lat, bc, tc, res, w, b);
      chk("t4_busy_write_ignored", w[1], 16'h0000); chk("t4_l0_readback", w[0], 16'h1234);
      start_run(3'd2, 4'h5); measure(0, lat, bc, tc, res, w, b);
      chk("t5_first_result", res, 4'h7);
      start = 1'b1; n_layers = 3'd1; data_in = 4'hC;
      @(posedge clk); #1 start = 1'b0;
      measure(0, lat, bc, tc, res, w, b);
      chk("t5_b2b_latency", lat, 3); chk("t5_b2b_result", res, 4'hD);
      start_run(3'd4, 4'h2);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("t6_busy", busy, 0); chk("t6_done", done, 0); chk("t6_result", result, 0);
      start_run(3'd4, 4'h0); measure(0, lat, bc, tc, res, w, b);
      chk("t6_weights_cleared", w, 64'h0); chk("t6_bias_cleared", b, 64'h0);
      chk("t6_result_after", res, 4'h4);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
